// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port 32-bit RAM.
// Sub-word stores become a same-cycle read-merge-write; responses follow each grant by one cycle.
module mem_arbiter #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic [1:0]       req_i,
    input  logic [1:0]       we_i,
    input  logic [1:0][31:0] addr_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic [1:0]       gnt_o,
    output logic [1:0]       rvalid_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    output logic [31:0]      mem_addr_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i
);

    logic        last_q;
    logic        sel;
    logic        any_gnt;
    logic [31:0] addr;
    logic        is_store;
    logic        out_of_range;
    logic        misaligned;
    logic        fault;
    logic [31:0] merged;
    logic        unused_we0;

    assign unused_we0 = we_i[0];

    // Tie goes to the port that was not granted most recently.
    always_comb begin
        gnt_o = 2'b00;
        if (rst_ni) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    assign any_gnt  = |gnt_o;
    assign sel      = gnt_o[1];
    assign addr     = sel ? addr_i[1] : addr_i[0];
    assign is_store = sel & we_i[1];

    assign out_of_range = |addr[31:AW+2];
    assign misaligned   = (|addr[1:0]) & (~is_store | (be_i == 4'hF));
    assign fault        = out_of_range | misaligned;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be_i[b] ? wdata_i[8*b +: 8] : mem_rdata_i[8*b +: 8];
        end
    end

    always_comb begin
        mem_addr_o  = 32'h0;
        mem_we_o    = 1'b0;
        mem_wdata_o = 32'h0;
        if (any_gnt) begin
            mem_addr_o = {{(32-AW){1'b0}}, addr[AW+1:2]};
            if (is_store && !fault && (be_i != 4'h0)) begin
                mem_we_o    = 1'b1;
                mem_wdata_o = merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q   <= 1'b1;
            rvalid_o <= 2'b00;
            rdata_o  <= 32'h0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= gnt_o;
            if (any_gnt) begin
                last_q  <= sel;
                rdata_o <= fault ? 32'h0 : mem_rdata_i;
                err_o   <= fault;
            end else begin
                err_o   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected responses, a monitor pops them.
module tb_mem_arbiter;

    logic             clk;
    logic             rst_ni;
    logic [1:0]       req_i;
    logic [1:0]       we_i;
    logic [1:0][31:0] addr_i;
    logic [3:0]       be_i;
    logic [31:0]      wdata_i;
    logic [1:0]       gnt_o;
    logic [1:0]       rvalid_o;
    logic [31:0]      rdata_o;
    logic             err_o;
    logic [31:0]      mem_addr_o;
    logic             mem_we_o;
    logic [31:0]      mem_wdata_o;
    logic [31:0]      mem_rdata_i;

    logic [31:0] ram [256];

    typedef struct packed {
        logic [1:0]  port;
        logic        err;
        logic [31:0] rd;
    } resp_t;

    resp_t q[$];
    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write at clock edge, pattern reload while in reset.
    assign mem_rdata_i = ram[mem_addr_o[7:0]];
    always @(posedge clk) begin
        if (!rst_ni) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA000_0000 | i;
        end else if (mem_we_o) begin
            ram[mem_addr_o[7:0]] <= mem_wdata_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (rvalid_o !== 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", {30'h0, rvalid_o}, 32'h0);
                end else begin
                    r = q.pop_front();
                    chk("rvalid_port", {30'h0, rvalid_o}, {30'h0, r.port});
                    chk("err", {31'h0, err_o}, {31'h0, r.err});
                    chk("rdata", rdata_o, r.rd);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] r, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [3:0] b, input logic [31:0] wd,
                         input logic [1:0] eg, input logic ck_mem,
                         input logic ewe, input logic [31:0] eaddr, input logic [31:0] ewd,
                         input logic push, input logic eerr, input logic [31:0] erd);
        resp_t e;
        req_i = r; we_i = w; addr_i[0] = a0; addr_i[1] = a1; be_i = b; wdata_i = wd;
        if (push) begin
            e.port = eg; e.err = eerr; e.rd = erd;
            q.push_back(e);
        end
        @(negedge clk);
        chk("gnt", {30'h0, gnt_o}, {30'h0, eg});
        if (ck_mem) begin
            chk("mem_we", {31'h0, mem_we_o}, {31'h0, ewe});
            chk("mem_addr", mem_addr_o, eaddr);
            chk("mem_wdata", mem_wdata_o, ewd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 2'b11; we_i = 2'b00; addr_i = '0; be_i = 4'h0; wdata_i = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {30'h0, gnt_o}, 32'h0);
        chk("rst_rvalid", {30'h0, rvalid_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // contention: reads of word 0 (port 0) and word 1 (port 1)
        issue(2'b11, 2'b00, 32'h0, 32'h4, 4'h0, 32'h0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'hA000_0000);
        issue(2'b11, 2'b00, 32'h0, 32'h4, 4'h0, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'hA000_0001);
        issue(2'b11, 2'b00, 32'h0, 32'h4, 4'h0, 32'h0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'hA000_0000);
        issue(2'b11, 2'b00, 32'h0, 32'h4, 4'h0, 32'h0, 2'b10, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'hA000_0001);

        // full store then fetch of the same word
        issue(2'b10, 2'b10, 32'h0, 32'h40, 4'hF, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hA000_0010);
        issue(2'b01, 2'b00, 32'h40, 32'h0, 4'h0, 32'h0, 2'b01, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        issue(2'b10, 2'b10, 32'h0, 32'h40, 4'hF, 32'h1122_3344, 2'b10, 1'b1, 1'b1, 32'h10, 32'h1122_3344, 1'b1, 1'b0, 32'hDEAD_BEEF);

        // partial store, zero-enable store, misaligned partial store
        issue(2'b10, 2'b10, 32'h0, 32'h40, 4'b0100, 32'h00AA_0000, 2'b10, 1'b1, 1'b1, 32'h10, 32'h11AA_3344, 1'b1, 1'b0, 32'h1122_3344);
        issue(2'b10, 2'b10, 32'h0, 32'h40, 4'b0000, 32'hFFFF_FFFF, 2'b10, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h11AA_3344);
        issue(2'b01, 2'b00, 32'h40, 32'h0, 4'h0, 32'h0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'h11AA_3344);
        issue(2'b10, 2'b10, 32'h0, 32'h41, 4'b0010, 32'h0000_5500, 2'b10, 1'b1, 1'b1, 32'h10, 32'h11AA_5544, 1'b1, 1'b0, 32'h11AA_3344);
        issue(2'b01, 2'b00, 32'h40, 32'h0, 4'h0, 32'h0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'h11AA_5544);

        // faults
        issue(2'b01, 2'b00, 32'h402, 32'h0, 4'h0, 32'h0, 2'b01, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        issue(2'b10, 2'b00, 32'h0, 32'h42, 4'h0, 32'h0, 2'b10, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h0);
        issue(2'b10, 2'b10, 32'h0, 32'h400, 4'hF, 32'h1234_5678, 2'b10, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
        issue(2'b01, 2'b00, 32'h0, 32'h0, 4'h0, 32'h0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'hA000_0000);

        // idle cycle drives zeros to the RAM
        issue(2'b00, 2'b00, 32'h44, 32'h48, 4'hF, 32'hFFFF_FFFF, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // reset mid-operation: port 0 granted alone (last=port 0), then reset drops the response
        issue(2'b01, 2'b00, 32'h0, 32'h0, 4'h0, 32'h0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0);
        req_i = 2'b11;
        rst_ni = 1'b0;
        #1;
        chk("midrst_rvalid", {30'h0, rvalid_o}, 32'h0);
        chk("midrst_gnt", {30'h0, gnt_o}, 32'h0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        issue(2'b11, 2'b00, 32'h0, 32'h4, 4'h0, 32'h0, 2'b01, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'hA000_0000);
        issue(2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        chk("pending_responses", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

endmodule
